fft_bitrev_reader: RTL and testbench
====================================

// Module: fft_bitrev_reader
// PURPOSE
//  Read-side sequencer for dual_prot_ram port B. Once the write side has filled a
//  frame of 2^N_LOG2 complex samples, it reads the whole frame out through port B,
//  in bit-reversed address order, and presents it as a valid/ready stream to the
//  FFT_base2 butterfly stage. It absorbs the RAM's 1-cycle read latency and
//  downstream backpressure with a 4-entry output FIFO.
// PARAMETERS
//  DATA_WIDTH  8   real/imag component width; one sample = 2*DATA_WIDTH bits
//  CMD_WIDTH   10  RAM address width
//  N_LOG2      4   log2(frame length); must satisfy N_LOG2 <= CMD_WIDTH
//  BASE_ADDR   0   first RAM address of the frame
// PORTS
//  CLK         in   1             single clock; RAM port B runs on it (CLKB=CLK)
//  RST         in   1             asynchronous reset, active-high
//  START       in   1             1-cycle pulse: begin reading one frame
//  BUSY        out  1             high from the cycle after START until DONE
//  DONE        out  1             1-cycle pulse, registered, after last handshake
//  ENB         out  1             RAM port B enable (combinational, see below)
//  WEB         out  1             RAM port B write enable, constant 0
//  ADDRB       out  CMD_WIDTH     RAM port B address
//  DOB         in   2*DATA_WIDTH  RAM port B read data, valid cycle after ENB
//  DOUT        out  2*DATA_WIDTH  stream data = FIFO head
//  DOUT_VALID  out  1             FIFO not empty
//  DOUT_READY  in   1             downstream accept; handshake = VALID & READY
//  DOUT_LAST   out  1             high with the frame's final sample
// BEHAVIOUR
//  - Reset (async, any state): state IDLE; cnt, in-flight flag, FIFO count = 0.
//    All outputs 0 at once: BUSY, DONE, ENB, ADDRB, DOUT, DOUT_VALID, DOUT_LAST.
//  - FSM IDLE -> READ on START. READ -> DRAIN when issue count reaches 2^N_LOG2.
//    DRAIN -> IDLE when FIFO is empty and nothing is in flight.
//    DONE pulses on the DRAIN->IDLE edge. START is ignored while BUSY.
//  - Issue: ENB = (state==READ) & (cnt < 2^N_LOG2) & (fifo_cnt + inflight < 4).
//    cnt is N_LOG2+1 bits and increments on each issue.
//  - ADDRB = (BASE_ADDR + idx(cnt[N_LOG2-1:0])) mod 2^CMD_WIDTH. ADDRB holds its
//    value while ENB is low.
//  - Latency: ENB in cycle c sets inflight at the end of c. DOB is captured into
//    the FIFO at the end of c+1, giving DOUT_VALID in c+2. So START in cycle 0 ->
//    first ENB in cycle 1 -> first DOUT_VALID in cycle 3.
//  - Throughput: with DOUT_READY held at 1, one sample per cycle and no bubbles
//    after the first. The FIFO is never overrun; a push and a pop in the same
//    cycle leave the count unchanged.
//  - Stream rules: DOUT and DOUT_LAST stay stable while VALID & !READY. VALID never
//    drops without a handshake. DOUT_LAST is carried in the FIFO entry, tagged on
//    issue index 2^N_LOG2-1.
//  - Boundary cases:
//    - FIFO full: no issue.
//    - FIFO empty in DRAIN: wait for inflight to clear.
//    - N_LOG2=0: one-sample frame, that sample carries LAST.
//    - BASE_ADDR near the top of the address space: ADDRB wraps modulo 2^CMD_WIDTH.
//    - RST mid-frame: frame abandoned, FIFO contents discarded. The next START
//      restarts at index 0.
// CONFIGURATION
//  FFT_READER_BITREV_EN defined: idx(k) = k with its N_LOG2 bits reversed
//  (decimation-in-time input order).
//  Undefined: idx(k) = k (linear readout, used for result dump/debug). All timing
//  and handshake behaviour is identical in both builds.
// TESTING (N_LOG2=4, DATA_WIDTH=8, RAM preloaded with mem[BASE_ADDR+i]=i)
//  1. RST high mid-clock -> all outputs 0 before the next CLK edge; released ->
//     IDLE, no ENB.
//  2. Macro defined, READY=1, START pulse -> DOUT = 0,8,4,12,2,10,6,14,1,9,5,13,
//     3,11,7,15 on 16 consecutive VALID cycles starting at cycle 3. LAST only on 15.
//     DONE one cycle after the last handshake. WEB always 0.
//  3. READY toggling 1,0,1,0 (then random) -> same sequence, no loss or duplication.
//     DOUT stable while stalled. ENB low whenever fifo_cnt+inflight = 4.
//  4. START re-pulsed at cycle 6 while BUSY -> ignored, exactly 16 outputs.
//     START after DONE -> identical second frame.
//  5. RST at the 5th handshake -> outputs 0 immediately. New START -> frame restarts
//     at DOUT=0. BASE_ADDR=1020, CMD_WIDTH=10 -> ADDRB wraps 1023 -> 0.
//  6. Macro undefined -> DOUT = 0,1,2,...,15 with identical timing to test 2.

Source files
------------

// File: rtl/fft_bitrev_reader.sv
// Port-B read sequencer: streams one 2^N_LOG2-sample frame out of RAM through a 4-entry FIFO.
// Define FFT_READER_BITREV_EN for bit-reversed readout; leave it undefined for linear order.
`timescale 1ns/1ps
module fft_bitrev_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CMD_WIDTH  = 10,
  parameter int unsigned N_LOG2     = 4,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ENB,
  output logic                    WEB,
  output logic [CMD_WIDTH-1:0]    ADDRB,
  input  logic [2*DATA_WIDTH-1:0] DOB,
  output logic [2*DATA_WIDTH-1:0] DOUT,
  output logic                    DOUT_VALID,
  input  logic                    DOUT_READY,
  output logic                    DOUT_LAST
);

  localparam int unsigned SW    = 2 * DATA_WIDTH;
  localparam int unsigned CW    = N_LOG2 + 1;
  localparam int unsigned IW    = (N_LOG2 > 0) ? N_LOG2 : 1;
  localparam int unsigned DEPTH = 4;
  localparam logic [CW-1:0] FRAME    = CW'(1 << N_LOG2);
  localparam logic [CW-1:0] LAST_IDX = CW'((1 << N_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t               state;
  state_t               state_nx;
  logic [CW-1:0]        cnt;
  logic                 inflight;
  logic                 inflight_last;
  logic [2:0]           fifo_cnt;
  logic [1:0]           wr_ptr;
  logic [1:0]           rd_ptr;
  logic [SW-1:0]        fifo_data [DEPTH];
  logic [DEPTH-1:0]     fifo_last;
  logic [CMD_WIDTH-1:0] addr_hold;
  logic [CMD_WIDTH-1:0] addr_c;
  logic [IW-1:0]        idx_c;
  logic [3:0]           occ_c;
  logic                 issue_c;
  logic                 push_c;
  logic                 pop_c;
  logic                 done_c;

  // Frame index -> RAM offset
  if (N_LOG2 == 0) begin : g_idx_zero
    assign idx_c = '0;
  end else begin : g_idx
    for (genvar g = 0; g < N_LOG2; g++) begin : g_bit
`ifdef FFT_READER_BITREV_EN
      assign idx_c[N_LOG2-1-g] = cnt[g];
`else
      assign idx_c[g] = cnt[g];
`endif
    end
  end

  assign addr_c  = CMD_WIDTH'(BASE_ADDR + 32'(idx_c));
  // Reads in flight count against FIFO space so a returning read always has a slot
  assign occ_c   = 4'(fifo_cnt) + 4'(inflight);
  assign issue_c = (state == READ) && (cnt < FRAME) && (occ_c < 4'd4);
  assign push_c  = inflight;
  assign pop_c   = DOUT_VALID && DOUT_READY;

  assign ENB        = issue_c;
  assign WEB        = 1'b0;
  assign ADDRB      = issue_c ? addr_c : addr_hold;
  assign BUSY       = (state != IDLE);
  assign DOUT_VALID = (fifo_cnt != 3'd0);
  assign DOUT       = fifo_data[rd_ptr];
  assign DOUT_LAST  = DOUT_VALID && fifo_last[rd_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state; DRAIN ends the cycle the final sample is accepted
  always_comb begin
    state_nx = state;
    done_c   = 1'b0;
    case (state)
      IDLE:  if (START) state_nx = READ;
      READ:  if (issue_c && (cnt == LAST_IDX)) state_nx = DRAIN;
      DRAIN: begin
        if (!inflight && ((fifo_cnt == 3'd0) || ((fifo_cnt == 3'd1) && pop_c))) begin
          state_nx = IDLE;
          done_c   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      addr_hold     <= '0;
      DONE          <= 1'b0;
    end else begin
      DONE          <= done_c;
      inflight      <= issue_c;
      inflight_last <= issue_c && (cnt == LAST_IDX);
      if ((state == IDLE) && START) cnt <= '0;
      else if (issue_c)             cnt <= cnt + CW'(1);
      if (issue_c) addr_hold <= addr_c;
    end
  end

  // Output FIFO; read data lands one cycle after its issue
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fifo_cnt  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_last <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_data[i] <= '0;
    end else begin
      if (push_c) begin
        fifo_data[wr_ptr] <= DOB;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= wr_ptr + 2'd1;
      end
      if (pop_c) rd_ptr <= rd_ptr + 2'd1;
      case ({push_c, pop_c})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reader.sv
// Directed bench for fft_bitrev_reader: ordering, timing, backpressure, reset and address wrap.
`timescale 1ns/1ps
module tb_fft_bitrev_reader;

  localparam int NF = 16;

  logic        clk = 1'b0;
  logic        rst, start, start2, ready;
  logic        busy, done, enb, web, valid, last;
  logic [9:0]  addrb;
  logic [15:0] dob, dout;
  logic        busy2, done2, enb2, web2, valid2, last2;
  logic [9:0]  addrb2;
  logic [15:0] dob2, dout2;
  logic [15:0] ram0 [1024];
  logic [15:0] ram1 [1024];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] lin;
    logic [15:0] rev;
    logic        last;
  } exp_t;
  typedef struct {
    int ready_mode;
    bit repulse;
  } cfg_t;

  exp_t exp_tab [NF];
  cfg_t cfgs [5];

  fft_bitrev_reader #(.DATA_WIDTH(8), .CMD_WIDTH(10), .N_LOG2(4), .BASE_ADDR(0)) dut (
    .CLK(clk), .RST(rst), .START(start), .BUSY(busy), .DONE(done), .ENB(enb), .WEB(web),
    .ADDRB(addrb), .DOB(dob), .DOUT(dout), .DOUT_VALID(valid), .DOUT_READY(ready),
    .DOUT_LAST(last));

  fft_bitrev_reader #(.DATA_WIDTH(8), .CMD_WIDTH(10), .N_LOG2(4), .BASE_ADDR(1020)) dut_wrap (
    .CLK(clk), .RST(rst), .START(start2), .BUSY(busy2), .DONE(done2), .ENB(enb2), .WEB(web2),
    .ADDRB(addrb2), .DOB(dob2), .DOUT(dout2), .DOUT_VALID(valid2), .DOUT_READY(1'b1),
    .DOUT_LAST(last2));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (enb)  dob  <= ram0[addrb];
    if (enb2) dob2 <= ram1[addrb2];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(input int k);
    int r;
`ifdef FFT_READER_BITREV_EN
    r = 0;
    for (int b = 0; b < 4; b++) r = r | (((k >> b) & 1) << (3 - b));
`else
    r = k;
`endif
    return r;
  endfunction

  function automatic logic [15:0] exp_dout(input int n);
`ifdef FFT_READER_BITREV_EN
    return exp_tab[n].rev;
`else
    return exp_tab[n].lin;
`endif
  endfunction

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"},  32'(busy),  0);
    chk({name, "_done"},  32'(done),  0);
    chk({name, "_enb"},   32'(enb),   0);
    chk({name, "_addrb"}, 32'(addrb), 0);
    chk({name, "_dout"},  32'(dout),  0);
    chk({name, "_valid"}, 32'(valid), 0);
    chk({name, "_last"},  32'(last),  0);
  endtask

  // One frame on the main DUT with the given READY pattern
  task automatic run_frame(input int mode, input bit repulse);
    int n, cyc, first_v, last_hs, issued;
    bit prev_stall, done_seen;
    logic [15:0] prev_dout;
    logic prev_last;
    n = 0; issued = 0; first_v = -1; last_hs = -1;
    prev_stall = 0; done_seen = 0; prev_dout = '0; prev_last = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    chk("busy_after_start", 32'(busy), 1);
    while (cyc < 200 && !done_seen) begin
      if (repulse) start = (cyc == 6);
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (cyc <= 10) ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (prev_stall) begin
        chk("stall_valid", 32'(valid), 1);
        chk("stall_dout", 32'(dout), 32'(prev_dout));
        chk("stall_last", 32'(last), 32'(prev_last));
      end
      if (enb) begin
        issued++;
        chk("addrb", 32'(addrb), 32'(idx_of(issued - 1)));
        chk("outstanding", 32'(issued - n <= 4), 1);
      end
      if (web) chk("web", 32'(web), 0);
      if (valid && first_v < 0) first_v = cyc;
      if (valid && ready) begin
        if (n < NF) begin
          chk("dout", 32'(dout), 32'(exp_dout(n)));
          chk("last", 32'(last), 32'(exp_tab[n].last));
        end
        n++;
        last_hs = cyc;
      end
      prev_stall = valid && !ready;
      prev_dout  = dout;
      prev_last  = last;
      if (done) begin
        done_seen = 1;
        chk("done_timing", 32'(cyc), 32'(last_hs + 1));
      end
      step();
      cyc++;
    end
    start = 1'b0;
    chk("frame_done", 32'(done_seen), 1);
    chk("sample_count", 32'(n), NF);
    chk("issue_count", 32'(issued), NF);
    if (mode == 0) begin
      chk("first_valid_cycle", 32'(first_v), 3);
      chk("last_hs_cycle", 32'(last_hs), 18);
    end
    chk("done_pulse_width", 32'(done), 0);
    chk("idle_after_done", 32'(busy), 0);
  endtask

  initial begin
    int rev_vals [NF] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int n, k;
    for (int i = 0; i < NF; i++) begin
      exp_tab[i].lin  = 16'(i);
      exp_tab[i].rev  = 16'(rev_vals[i]);
      exp_tab[i].last = (i == NF - 1);
    end
    cfgs[0] = '{0, 1'b0};
    cfgs[1] = '{1, 1'b0};
    cfgs[2] = '{2, 1'b0};
    cfgs[3] = '{0, 1'b1};
    cfgs[4] = '{0, 1'b0};
    for (int i = 0; i < 1024; i++) begin
      ram0[i] = 16'hdead;
      ram1[i] = 16'hbeef;
    end
    for (int i = 0; i < NF; i++) begin
      ram0[i] = 16'(i);
      ram1[(1020 + i) % 1024] = 16'(i);
    end

    rst = 1'b1; start = 1'b0; start2 = 1'b0; ready = 1'b0;
    #1;
    chk_all_zero("por");
    step(); step();
    rst = 1'b0;
    step();
    chk("idle_enb", 32'(enb), 0);
    chk("idle_busy", 32'(busy), 0);

    // Async reset mid-clock with the FIFO partly filled
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("pre_reset_valid", 32'(valid), 1);
    #3 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_enb", 32'(enb), 0);
    end

    for (int i = 0; i < 5; i++) run_frame(cfgs[i].ready_mode, cfgs[i].repulse);

    // Reset while the 5th handshake is offered, then a clean frame
    ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      if (valid) n++;
      step();
    end
    chk("fifth_offered", 32'(valid), 1);
    chk("fifth_value", 32'(dout), 32'(exp_dout(4)));
    rst = 1'b1;
    #1;
    chk_all_zero("hs5_rst");
    step();
    rst = 1'b0;
    step();
    run_frame(0, 1'b0);

    // Address wrap on the BASE_ADDR=1020 instance
    start2 = 1'b1; step(); start2 = 1'b0;
    n = 0; k = 0;
    for (int c = 0; c < 100; c++) begin
      if (enb2) begin
        chk("wrap_addrb", 32'(addrb2), 32'((1020 + idx_of(k)) % 1024));
        k++;
      end
      if (valid2) begin
        if (n < NF) chk("wrap_dout", 32'(dout2), 32'(exp_dout(n)));
        n++;
      end
      if (done2) break;
      step();
    end
    chk("wrap_issue_count", 32'(k), NF);
    chk("wrap_sample_count", 32'(n), NF);
    chk("wrap_web", 32'(web2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
